// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - segmented ripple-carry adder/subtractor, one SEG_W segment per stage
module pipelined_adder #(
   parameter int WIDTH = 16,
   parameter int SEG_W = 4
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             count,
   output logic             ovf
);
   localparam int STAGES = WIDTH / SEG_W;

   logic stall;

   if ((WIDTH % SEG_W) != 0) begin : g_bad_width
      $error("pipelined_adder: WIDTH must be a multiple of SEG_W");
   end

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // Operands are shifted down as they travel, so each stage always adds the low segment.
      localparam int RW = WIDTH - k * SEG_W;

      logic                   v_in;
      logic                   c_in;
      logic [RW-1:0]          a_in;
      logic [RW-1:0]          b_in;
      logic [SEG_W:0]         seg_sum;
      logic                   v_q;
      logic                   c_q;
      logic [(k+1)*SEG_W-1:0] s_q;

      if (k == 0) begin : g_first
         assign v_in = in_valid;
         assign c_in = sub | cin;
         assign a_in = in1;
         assign b_in = sub ? ~in2 : in2;
      end else begin : g_next
         assign v_in = g_stage[k-1].v_q;
         assign c_in = g_stage[k-1].c_q;
         assign a_in = g_stage[k-1].g_skew.a_q;
         assign b_in = g_stage[k-1].g_skew.b_q;
      end

      assign seg_sum = {1'b0, a_in[SEG_W-1:0]} + {1'b0, b_in[SEG_W-1:0]}
                     + {{SEG_W{1'b0}}, c_in};

      always_ff @(posedge sys_clk) begin
         if (sys_rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
         end else if (!stall) begin
            v_q <= v_in;
            c_q <= seg_sum[SEG_W];
         end
      end

      // Result deskew: finished low segments ride along below the newest one.
      if (k == 0) begin : g_sum_first
         always_ff @(posedge sys_clk) begin
            if (sys_rst)
               s_q <= '0;
            else if (!stall)
               s_q <= seg_sum[SEG_W-1:0];
         end
      end else begin : g_sum_next
         always_ff @(posedge sys_clk) begin
            if (sys_rst)
               s_q <= '0;
            else if (!stall)
               s_q <= {seg_sum[SEG_W-1:0], g_stage[k-1].s_q};
         end
      end

      if (k < STAGES - 1) begin : g_skew
         logic [RW-SEG_W-1:0] a_q;
         logic [RW-SEG_W-1:0] b_q;

         always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (!stall) begin
               a_q <= a_in[RW-1:SEG_W];
               b_q <= b_in[RW-1:SEG_W];
            end
         end
      end

      if (k == STAGES - 1) begin : g_last
         logic ovf_q;
         logic msb_carry_in;

         // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
         assign msb_carry_in = a_in[SEG_W-1] ^ b_in[SEG_W-1] ^ seg_sum[SEG_W-1];

         always_ff @(posedge sys_clk) begin
            if (sys_rst)
               ovf_q <= 1'b0;
            else if (!stall)
               ovf_q <= msb_carry_in ^ seg_sum[SEG_W];
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].v_q;
   assign sum       = g_stage[STAGES-1].s_q;
   assign count     = g_stage[STAGES-1].c_q;
   assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - scoreboard bench for pipelined_adder (WIDTH=16, SEG_W=4)
module tb_pipelined_adder;
   logic        sys_clk;
   logic        sys_rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in1;
   logic [15:0] in2;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        count;
   logic        ovf;

   int          errors = 0;
   int          checks = 0;
   int          n_out  = 0;
   logic [17:0] sb_q[$];
   logic [17:0] sb_exp;

   pipelined_adder #(.WIDTH(16), .SEG_W(4)) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in1      (in1),
      .in2      (in2),
      .cin      (cin),
      .sub      (sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .count    (count),
      .ovf      (ovf)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Whole-word reference: {sum, carry out, signed overflow}
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic c, input logic s);
      logic [15:0] bb;
      logic [16:0] full;
      logic        o;
      bb   = s ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + 17'(s ? 1'b1 : c);
      o    = (a[15] == bb[15]) && (full[15] != a[15]);
      return {full[15:0], full[16], o};
   endfunction

   always @(negedge sys_clk) begin
      if (sys_rst) begin
         sb_q.delete();
      end else begin
         if (in_valid && in_ready)
            sb_q.push_back(model(in1, in2, cin, sub));
         if (out_valid && out_ready) begin
            n_out++;
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL sb_spurious: got sum=%h count=%b ovf=%b, required no output", sum, count, ovf);
            end else begin
               sb_exp = sb_q.pop_front();
               if ({sum, count, ovf} !== sb_exp) begin
                  errors++;
                  $display("FAIL sb_result: got sum=%h count=%b ovf=%b, required sum=%h count=%b ovf=%b",
                           sum, count, ovf, sb_exp[17:2], sb_exp[1], sb_exp[0]);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic test_reset();
      sys_rst   = 1'b1;
      in_valid  = 1'b0;
      in1       = '0;
      in2       = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      sys_rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid: got %b, required 0", out_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
      tick();
   endtask

   task automatic test_directed();
      logic [15:0] va [6] = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'h0005, 16'h8000, 16'h0003};
      logic [15:0] vb [6] = '{16'h0001, 16'h0001, 16'h0F0F, 16'h0007, 16'h0001, 16'h0003};
      logic        vc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic        vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [17:0] ve [6] = '{{16'h0000, 1'b1, 1'b0}, {16'h8000, 1'b0, 1'b1},
                              {16'h2144, 1'b0, 1'b0}, {16'hFFFE, 1'b0, 1'b0},
                              {16'h7FFF, 1'b1, 1'b1}, {16'h0000, 1'b1, 1'b0}};
      int lat;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in1      = va[i];
         in2      = vb[i];
         cin      = vc[i];
         sub      = vs[i];
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         lat = 1;
         while (!out_valid && lat < 12) begin
            tick();
            lat++;
         end
         checks++;
         if (lat != 4) begin
            errors++;
            $display("FAIL directed_latency[%0d]: got %0d cycles, required 4", i, lat);
         end
         checks++;
         if ({sum, count, ovf} !== ve[i]) begin
            errors++;
            $display("FAIL directed_result[%0d]: got sum=%h count=%b ovf=%b, required sum=%h count=%b ovf=%b",
                     i, sum, count, ovf, ve[i][17:2], ve[i][1], ve[i][0]);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic exp_v;
      out_ready = 1'b1;
      for (int i = 0; i < 71; i++) begin
         if (i < 64) begin
            in1      = 16'($urandom);
            in2      = 16'($urandom);
            cin      = 1'($urandom);
            sub      = 1'($urandom);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         exp_v = (i + 1 >= 4) && (i + 1 <= 67);
         checks++;
         if (out_valid !== exp_v) begin
            errors++;
            $display("FAIL b2b_valid[cycle %0d]: got %b, required %b", i + 1, out_valid, exp_v);
         end
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_drain: got %0d pending, required 0", sb_q.size());
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] pa [8];
      logic [15:0] pb [8];
      logic [17:0] held;
      int          sent;
      int          n0;
      logic        accepted;
      sent = 0;
      n0   = n_out;
      held = '0;
      for (int i = 0; i < 8; i++) begin
         pa[i] = 16'($urandom);
         pb[i] = 16'($urandom);
      end
      for (int t = 0; t < 24; t++) begin
         out_ready = !(t >= 5 && t < 10);
         if (sent < 8) begin
            in1      = pa[sent];
            in2      = pb[sent];
            cin      = pa[sent][0];
            sub      = pb[sent][15];
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         accepted = in_valid && in_ready;
         if (t >= 5 && t < 10) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL bp_in_ready[t=%0d]: got %b, required 0", t, in_ready);
            end
            checks++;
            if (out_valid !== 1'b1) begin
               errors++;
               $display("FAIL bp_out_valid[t=%0d]: got %b, required 1", t, out_valid);
            end
            if (t == 5) begin
               held = {sum, count, ovf};
            end else begin
               checks++;
               if ({sum, count, ovf} !== held) begin
                  errors++;
                  $display("FAIL bp_stable[t=%0d]: got %h, required %h", t, {sum, count, ovf}, held);
               end
            end
         end
         @(posedge sys_clk);
         #1;
         if (accepted)
            sent++;
      end
      checks++;
      if (n_out - n0 != 8) begin
         errors++;
         $display("FAIL bp_count: got %0d results, required 8", n_out - n0);
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL bp_drain: got %0d pending, required 0", sb_q.size());
      end
   endtask

   task automatic test_reset_flush();
      int lat;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in1      = 16'h1111 * 16'(i + 1);
         in2      = 16'h0101;
         cin      = 1'b0;
         sub      = 1'b0;
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      sys_rst  = 1'b1;
      tick();
      sys_rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_out_valid: got %b, required 0", out_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_in_ready: got %b, required 1", in_ready);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_stale[%0d]: got out_valid=%b, required 0", i, out_valid);
         end
      end
      in1      = 16'h00FF;
      in2      = 16'h0F01;
      cin      = 1'b0;
      sub      = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 12) begin
         tick();
         lat++;
      end
      checks++;
      if (lat != 4) begin
         errors++;
         $display("FAIL flush_new_latency: got %0d cycles, required 4", lat);
      end
      checks++;
      if ({sum, count, ovf} !== {16'h1000, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL flush_new_result: got sum=%h count=%b ovf=%b, required sum=1000 count=0 ovf=0",
                  sum, count, ovf);
      end
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_reset_flush();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL final_drain: got %0d pending, required 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
